// File: rtl/inst_sram_like_bridge_pkg.sv
// Shared CPU-side bus bridge definitions: FSM encoding, transfer size, reset vector.
// The data-side bridge uses the same state encoding.
package inst_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } bridge_state_e;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] RESET_PC  = 32'hbfc00000;

endpackage

// File: rtl/inst_sram_like_bridge_if.sv
// sram-like bus handshake (req/addr_ok/data_ok) between a fetch bridge and the AXI/cache side.
interface inst_sram_like_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  inst_req;
  logic                  inst_wr;
  logic [1:0]            inst_size;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_WIDTH-1:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_sram_like_bridge.sv
// Fetch-stage SRAM port to sram-like bus bridge: single outstanding read,
// word buffered while the pipeline stalls, in-flight reads drained and dropped on flush.
module inst_sram_like_bridge
  import inst_sram_like_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_inst_en,
  input  logic [ADDR_WIDTH-1:0] cpu_inst_addr,
  output logic [DATA_WIDTH-1:0] cpu_inst_rdata,
  output logic                  i_stall,
  input  logic                  longest_stall,
  input  logic                  flush,
  inst_sram_like_bridge_if.master bus
);

  bridge_state_e         state_q, state_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  req_raw;
  logic                  avail;

  assign req_raw = (state_q == IDLE) & cpu_inst_en & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
    end
  end

  // A flush coincident with data_ok is treated like an earlier flush: the word is dropped.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    case (state_q)
      IDLE: begin
        if (req_raw && bus.inst_addr_ok) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.inst_data_ok) begin
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = IDLE;
          end else begin
            buf_d   = bus.inst_rdata;
            state_d = longest_stall ? HOLD : IDLE;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush || !longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign avail = ((state_q == WAIT_DATA) & bus.inst_data_ok & ~discard_q & ~flush)
               | (state_q == HOLD);

  // Request and returned word are forced quiet while reset is asserted.
  assign bus.inst_req   = req_raw & resetn;
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = SIZE_WORD;
  assign bus.inst_addr  = cpu_inst_addr;

  assign i_stall        = cpu_inst_en & ~avail;
  assign cpu_inst_rdata = !resetn            ? '0
                        : (state_q == HOLD)  ? buf_q
                        :                      bus.inst_rdata;

endmodule

// File: tb/tb_inst_sram_like_bridge.sv
// Directed self-checking bench for inst_sram_like_bridge.
module tb_inst_sram_like_bridge;
  import inst_sram_like_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_inst_en;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_rdata;
  logic        i_stall;
  logic        longest_stall;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

  inst_sram_like_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  inst_sram_like_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_inst_en   (cpu_inst_en),
    .cpu_inst_addr (cpu_inst_addr),
    .cpu_inst_rdata(cpu_inst_rdata),
    .i_stall       (i_stall),
    .longest_stall (longest_stall),
    .flush         (flush),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [31:0] addr, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic ls, input logic fl);
    cpu_inst_en      = en;
    cpu_inst_addr    = addr;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rd;
    longest_stall    = ls;
    flush            = fl;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, RESET_PC, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b exp 1", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", cpu_inst_rdata); end
    next_cycle(); next_cycle();
    resetn = 1'b1;
    drive(1'b1, RESET_PC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL rf_c0_req got %b exp 1", bus.inst_req); end
    n_tests++; if (bus.inst_addr !== 32'hbfc00000) begin n_fail++; $display("FAIL rf_c0_addr got %h exp bfc00000", bus.inst_addr); end
    n_tests++; if (bus.inst_wr !== 1'b0) begin n_fail++; $display("FAIL rf_wr got %b exp 0", bus.inst_wr); end
    n_tests++; if (bus.inst_size !== 2'b10) begin n_fail++; $display("FAIL rf_size got %b exp 10", bus.inst_size); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL rf_c0_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, RESET_PC, 1'b0, 1'b1, 32'h3c1d8000, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rf_c1_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL rf_c1_stall got %b exp 0", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h3c1d8000) begin n_fail++; $display("FAIL rf_c1_rdata got %h exp 3c1d8000", cpu_inst_rdata); end
    next_cycle();
    drive(1'b0, RESET_PC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rf_idle_req got %b exp 0", bus.inst_req); end
    next_cycle();
  endtask

  task automatic test_slow_addr_ok();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hbfc00004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL slow_req[%0d] got %b exp 1", i, bus.inst_req); end
      n_tests++; if (bus.inst_addr !== 32'hbfc00004) begin n_fail++; $display("FAIL slow_addr[%0d] got %h exp bfc00004", i, bus.inst_addr); end
      n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL slow_stall[%0d] got %b exp 1", i, i_stall); end
      next_cycle();
    end
    drive(1'b1, 32'hbfc00004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL slow_req_grant got %b exp 1", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL slow_stall_grant got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL slow_wait_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL slow_wait_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00004, 1'b0, 1'b1, 32'h27bdffe8, 1'b0, 1'b0);
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL slow_data_stall got %b exp 0", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h27bdffe8) begin n_fail++; $display("FAIL slow_data_rdata got %h exp 27bdffe8", cpu_inst_rdata); end
    next_cycle();
  endtask

  task automatic test_hold();
    drive(1'b1, 32'hbfc00008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc00008, 1'b0, 1'b1, 32'h24020001, 1'b1, 1'b0);
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL hold_dok_stall got %b exp 0", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h24020001) begin n_fail++; $display("FAIL hold_dok_rdata got %h exp 24020001", cpu_inst_rdata); end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      // cycle 2 carries a stray data_ok that must be ignored
      drive(1'b1, 32'hbfc00008, 1'b1, (i == 2), 32'h11111111 * (i + 1), 1'b1, 1'b0);
      n_tests++; if (cpu_inst_rdata !== 32'h24020001) begin n_fail++; $display("FAIL hold_rdata[%0d] got %h exp 24020001", i, cpu_inst_rdata); end
      n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall[%0d] got %b exp 0", i, i_stall); end
      n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %b exp 0", i, bus.inst_req); end
      next_cycle();
    end
    drive(1'b1, 32'hbfc00008, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0);
    n_tests++; if (cpu_inst_rdata !== 32'h24020001) begin n_fail++; $display("FAIL hold_last_rdata got %h exp 24020001", cpu_inst_rdata); end
    next_cycle();
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b0, 32'h77777777, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL hold_exit_req got %b exp 1", bus.inst_req); end
    n_tests++; if (cpu_inst_rdata !== 32'h77777777) begin n_fail++; $display("FAIL hold_exit_rdata got %h exp 77777777", cpu_inst_rdata); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL hold_exit_stall got %b exp 1", i_stall); end
    drive(1'b0, 32'hbfc0000c, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    // flush while holding: buffer dropped, back to IDLE
    drive(1'b1, 32'hbfc0000c, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b1, 32'hafbf0014, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL hflush_req got %b exp 0", bus.inst_req); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'h0000000f, 1'b1, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL hflush_idle_req got %b exp 1", bus.inst_req); end
    n_tests++; if (cpu_inst_rdata !== 32'h0000000f) begin n_fail++; $display("FAIL hflush_rdata got %h exp 0000000f", cpu_inst_rdata); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
  endtask

  task automatic test_flush_in_flight();
    drive(1'b1, 32'hbfc00010, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL fl_idle_req got %b exp 0", bus.inst_req); end
    next_cycle();
    drive(1'b1, 32'hbfc00010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc00010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL fl_c1_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fl_c1_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL fl_c2_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fl_c2_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b0);
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fl_c3_stall got %b exp 1", i_stall); end
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL fl_c3_req got %b exp 0", bus.inst_req); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fl_new_req got %b exp 1", bus.inst_req); end
    n_tests++; if (bus.inst_addr !== 32'hbfc00380) begin n_fail++; $display("FAIL fl_new_addr got %h exp bfc00380", bus.inst_addr); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fl_new_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b0, 1'b1, 32'h401a6800, 1'b0, 1'b0);
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL fl_new_data_stall got %b exp 0", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h401a6800) begin n_fail++; $display("FAIL fl_new_rdata got %h exp 401a6800", cpu_inst_rdata); end
    next_cycle();
    // flush in the same cycle as data_ok
    drive(1'b1, 32'hbfc00384, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc00384, 1'b0, 1'b1, 32'hcafef00d, 1'b0, 1'b1);
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fl_coinc_stall got %b exp 1", i_stall); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fl_coinc_req got %b exp 1", bus.inst_req); end
    next_cycle();
    drive(1'b1, 32'hbfc00380, 1'b0, 1'b1, 32'h3c1b8000, 1'b0, 1'b0);
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL fl_coinc_next_stall got %b exp 0", i_stall); end
    n_tests++; if (cpu_inst_rdata !== 32'h3c1b8000) begin n_fail++; $display("FAIL fl_coinc_next_rdata got %h exp 3c1b8000", cpu_inst_rdata); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'hbfc00020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'hbfc00020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL ar_req got %b exp 0", bus.inst_req); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL ar_stall got %b exp 1", i_stall); end
    next_cycle();
    resetn = 1'b1;
    drive(1'b1, 32'hbfc00000, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0);
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL ar_stray_stall got %b exp 1", i_stall); end
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL ar_stray_req got %b exp 1", bus.inst_req); end
    next_cycle();
    drive(1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL ar_after_req got %b exp 1", bus.inst_req); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'h3c088000; words[1] = 32'h35080010;
    words[2] = 32'h01000008; words[3] = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hbfc00100 + 32'(4 * i), 1'b1, 1'b0, 32'hffffffff, 1'b0, 1'b0);
      n_tests++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req[%0d] got %b exp 1", i, bus.inst_req); end
      n_tests++; if (bus.inst_addr !== 32'hbfc00100 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h", i, bus.inst_addr); end
      n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_req[%0d] got %b exp 1", i, i_stall); end
      next_cycle();
      drive(1'b1, 32'hbfc00100 + 32'(4 * i), 1'b1, 1'b1, words[i], 1'b0, 1'b0);
      n_tests++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL b2b_dreq[%0d] got %b exp 0", i, bus.inst_req); end
      n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_dok[%0d] got %b exp 0", i, i_stall); end
      n_tests++; if (cpu_inst_rdata !== words[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, cpu_inst_rdata, words[i]); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_slow_addr_ok();
    test_hold();
    test_flush_in_flight();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sram_like_bridge.md
Name: inst_sram_like_bridge

Overview:
- Converts the CPU fetch stage's SRAM-style instruction port (address out, word back, stall) into the sram-like bus handshake (req/addr_ok/data_ok) toward the AXI/cache interface.
- Acts as the memory-side responder for every fetch address the PC register issues, starting with the reset vector 0xbfc00000.
- Raises stall until the word arrives, then holds the word while the pipeline stays stalled.
- Any transaction still in flight when the pipeline is flushed is completed on the bus, and its data is discarded.

Parameters:
ADDR_WIDTH, 32, fetch address width
DATA_WIDTH, 32, instruction word width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
cpu_inst_en  input  1  fetch stage requests a word this cycle
cpu_inst_addr  input  ADDR_WIDTH  fetch address (PC), stable while i_stall=1
cpu_inst_rdata  output  DATA_WIDTH  returned instruction word
i_stall  output  1  fetch not yet satisfied; freezes PC/IF
longest_stall  input  1  global pipeline stall (any stage); word must be held while high
flush  input  1  exception/eret flush; current fetch is abandoned
inst_req  output  1  bus request
inst_wr  output  1  always 0
inst_size  output  2  always 2'b10 (word)
inst_addr  output  ADDR_WIDTH  = cpu_inst_addr
inst_addr_ok  input  1  bus accepted address
inst_data_ok  input  1  bus returns data
inst_rdata  input  DATA_WIDTH  bus read data

Behaviour:
- Reset: clk and asynchronous active-low reset resetn; resetn=0 forces state=IDLE, discard=0, buffer=0. Outputs during reset: inst_req=0, i_stall=cpu_inst_en, cpu_inst_rdata=0.
- States: IDLE, WAIT_DATA, HOLD. There is a single outstanding transaction, never two.
- IDLE:
  - inst_req = cpu_inst_en & ~flush (combinational). inst_req stays high, with inst_addr unchanged, until inst_addr_ok.
  - req & addr_ok -> WAIT_DATA.
  - Otherwise remain in IDLE.
- WAIT_DATA:
  - inst_req=0.
  - On inst_data_ok with discard=0: buffer<=inst_rdata. Next state is HOLD if longest_stall=1, else IDLE.
  - On inst_data_ok with discard=1: drop the data, clear discard, go to IDLE.
  - flush while in WAIT_DATA (data_ok not yet seen) sets discard=1. flush coincident with data_ok counts as discard, so the data is dropped.
- HOLD:
  - inst_req=0.
  - ~longest_stall -> IDLE.
  - flush -> IDLE, buffer contents dead.
- i_stall = cpu_inst_en & ~avail, where avail = (WAIT_DATA & data_ok & ~discard & ~flush) | HOLD.
- cpu_inst_rdata: in HOLD, the buffer; otherwise inst_rdata (same-cycle bypass).
- Latency: minimum 1 cycle (addr_ok in the request cycle, data_ok the next cycle). i_stall is low in the data_ok cycle.
- Back-to-back fetches: data_ok with longest_stall=0 returns to IDLE. The next req can be issued the following cycle.
- Illegal input: inst_data_ok in IDLE or HOLD is ignored, with no state change. inst_addr_ok while inst_req=0 is ignored.
- No registered path from cpu_inst_addr; address is pure pass-through.
- resetn asserted mid-transaction returns to IDLE immediately. The bus is reset in the same domain, so no drain is needed.

Decomposition:
- Shared CPU defines file: state encoding constants (IDLE=2'd0, WAIT_DATA=2'd1, HOLD=2'd2), SIZE_WORD=2'b10, RESET_PC=32'hbfc00000.
- No sub-module. A single FSM plus a data buffer is natural. A data-side twin (data_sram_like_bridge) will share the same encoding.

Test Plan:
- Reset fetch:
  - Stimulus: release resetn; en=1, addr=0xbfc00000; addr_ok in cycle 0; data_ok with rdata=0x3c1d8000 in cycle 1.
  - Response: inst_req high only in cycle 0; i_stall=1 in cycle 0, 0 in cycle 1; cpu_inst_rdata=0x3c1d8000 in cycle 1.
- Slow addr_ok:
  - Stimulus: addr_ok delayed 3 cycles.
  - Response: inst_req and inst_addr stable for 4 cycles; i_stall stays 1 until the data_ok cycle.
- Hold:
  - Stimulus: data_ok with rdata=0x24020001 while longest_stall=1 for 5 cycles.
  - Response: HOLD entered; cpu_inst_rdata=0x24020001 and i_stall=0 for all 5 cycles even as inst_rdata changes; IDLE after longest_stall falls.
- Flush in flight:
  - Stimulus: flush in cycle 1 of WAIT_DATA; data_ok in cycle 3 with 0xdeadbeef.
  - Response: the word is never presented as valid; i_stall stays 1 if en=1; a new req for 0xbfc00380 is issued in the cycle after data_ok, with no overlapping req before it.
- Async reset:
  - Stimulus: resetn pulsed low mid WAIT_DATA, between clock edges.
  - Response: inst_req=0 and state=IDLE immediately; a stray data_ok afterward is ignored.
- Back-to-back:
  - Stimulus: 4 sequential PCs, each granted addr_ok immediately with data_ok the next cycle.
  - Response: each word appears in order; no duplicated or dropped fetch.
